// File: rtl/johnson_ring_counter.sv
// Parametrised shift-register counter: Johnson (twisted ring, 2*WIDTH states)
// or one-hot ring (WIDTH states). Supports count enable, direction, a checked
// parallel load and self-correction of illegal states. It also provides a
// registered phase index and a combinational terminal-count strobe.
module johnson_ring_counter #(
  parameter  int WIDTH   = 4,
  parameter  int MODE    = 0,
  localparam int NSTATES = (MODE == 0) ? 2 * WIDTH : WIDTH,
  localparam int PW      = $clog2(2 * WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             tc,
  output logic             illegal
);

  // Johnson mode inverts the bit that wraps around; ring mode passes it through.
  localparam logic TWIST = (MODE == 0);

  localparam logic [WIDTH-1:0] RESET_VAL =
    (MODE == 0) ? '0 : {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic          legal;
    logic [PW-1:0] phase;
  } decode_t;

  // Pattern held in state k of the forward sequence.
  function automatic logic [WIDTH-1:0] f_pattern(input int k);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] one;
    ones = '1;
    one  = {{(WIDTH-1){1'b0}}, 1'b1};
    if (MODE == 0) begin
      if (k <= WIDTH) return ~(ones >> k);   // top k bits set
      else            return ones >> (k - WIDTH); // top k-WIDTH bits clear
    end
    return one << (WIDTH - 1 - k);
  endfunction

  // Legality test and phase index of an arbitrary register value.
  function automatic decode_t f_decode(input logic [WIDTH-1:0] v);
    decode_t d;
    d.legal = 1'b0;
    d.phase = '0;
    for (int k = 0; k < NSTATES; k++) begin
      if (v == f_pattern(k)) begin
        d.legal = 1'b1;
        d.phase = PW'(k);
      end
    end
    return d;
  endfunction

  logic [WIDTH-1:0] r_out;
  logic [PW-1:0]    r_phase;
  logic             r_illegal;

  decode_t          w_load_dec;
  logic             w_cur_legal;
  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_rev;
  logic [PW-1:0]    w_phase_inc;
  logic [PW-1:0]    w_phase_dec;
  logic             w_tc;

  assign w_load_dec  = f_decode(load_val);
  assign w_cur_legal = f_decode(r_out).legal;

  assign w_fwd = {r_out[0] ^ TWIST, r_out[WIDTH-1:1]};
  assign w_rev = {r_out[WIDTH-2:0], r_out[WIDTH-1] ^ TWIST};

  assign w_phase_inc = (r_phase == PW'(NSTATES - 1)) ? '0 : r_phase + PW'(1);
  assign w_phase_dec = (r_phase == '0) ? PW'(NSTATES - 1) : r_phase - PW'(1);

  // Terminal count: the step enabled on this edge wraps the sequence.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    w_tc = 1'b0;
    if (en && !load && !reset) begin
      w_tc = dir ? (r_phase == '0) : (r_phase == PW'(NSTATES - 1));
    end
  end

  // State update: reset > load > correction > step > hold.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      r_out     <= RESET_VAL;
      r_phase   <= '0;
      r_illegal <= 1'b0;
    end else if (load) begin
      if (w_load_dec.legal) begin
        r_out     <= load_val;
        r_phase   <= w_load_dec.phase;
        r_illegal <= 1'b0;
      end else begin
        r_out     <= RESET_VAL;
        r_phase   <= '0;
        r_illegal <= 1'b1;
      end
    end else if (!w_cur_legal) begin
      r_out     <= RESET_VAL;
      r_phase   <= '0;
      r_illegal <= 1'b1;
    end else begin
      r_illegal <= 1'b0;
      if (en) begin
        if (dir) begin
          r_out   <= w_rev;
          r_phase <= w_phase_dec;
        end else begin
          r_out   <= w_fwd;
          r_phase <= w_phase_inc;
        end
      end
    end
  end

  assign out     = r_out;
  assign phase   = r_phase;
  assign illegal = r_illegal;
  assign tc      = w_tc;

endmodule
